// File: rtl/bus_arbiter.sv
// Two-master (fetch / load-store) arbiter onto a single shared system bus.
// One transaction at a time, bounded MEM-over-IF priority, fetch-response
// discard on jump flush, and timeout abort of hung transfers.
//
// Handshake: a master raises req with its attributes and holds them until it
// sees ack (done, rdata valid that cycle) or err (aborted). The bus side is a
// classic cyc/ack cycle: cyc stays high from grant until the slave's one-cycle
// ack or until the timeout abort, whichever comes first; ack wins a tie.
module bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MEM_STREAK_MAX = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_ack_o,
  output logic                if_err_o,
  output logic                stallreq_from_if_o,
  input  logic                mem_req_i,
  input  logic                mem_we_i,
  input  logic [DATA_W/8-1:0] mem_sel_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                mem_ack_o,
  output logic                mem_err_o,
  output logic                stallreq_from_mem_o,
  output logic                bus_cyc_o,
  output logic                bus_we_o,
  output logic [DATA_W/8-1:0] bus_sel_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  input  logic [DATA_W-1:0]   bus_rdata_i,
  input  logic                bus_ack_i,
  output logic [1:0]          dbg_state
);

  localparam int TW  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SKW = $clog2(MEM_STREAK_MAX + 1);
  localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SKW-1:0] S_MAX  = SKW'(MEM_STREAK_MAX);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_XFER  = 2'd1,
    MEM_XFER = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [TW-1:0]  tcnt;
  logic [SKW-1:0] streak;
  logic           discard;
  logic           grant_if;
  logic           grant_mem;
  logic           if_ok;
  logic           mem_ok;
  logic           timeout_hit;

  // A master whose err pulse is showing this cycle still holds req (it only
  // reacts after the edge), so it is masked to avoid re-granting the aborted op.
  assign if_ok       = if_req_i & ~if_err_o;
  assign mem_ok      = mem_req_i & ~mem_err_o;
  assign timeout_hit = (state != IDLE) & ~bus_ack_i & (tcnt == T_LAST);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and grant decision; MEM wins contention until its streak is spent.
  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    case (state)
      IDLE: begin
        if (if_ok && mem_ok) begin
          if (streak == S_MAX) grant_if  = 1'b1;
          else                 grant_mem = 1'b1;
        end else if (if_ok) begin
          grant_if = 1'b1;
        end else if (mem_ok) begin
          grant_mem = 1'b1;
        end
        if (grant_if)  state_nxt = IF_XFER;
        if (grant_mem) state_nxt = MEM_XFER;
      end
      IF_XFER, MEM_XFER: begin
        if (bus_ack_i || timeout_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Master-facing outputs: acks are combinational so data passes straight through.
  always_comb begin
    if_ack_o            = bus_ack_i & (state == IF_XFER) & ~discard;
    mem_ack_o           = bus_ack_i & (state == MEM_XFER) & ~discard;
    if_rdata_o          = bus_rdata_i;
    mem_rdata_o         = bus_rdata_i;
    stallreq_from_if_o  = if_req_i & ~if_ack_o;
    stallreq_from_mem_o = mem_req_i & ~mem_ack_o;
    dbg_state           = state;
  end

  // Bus attribute registers, timeout/streak counters, discard flag, err pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus_cyc_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      tcnt        <= '0;
      streak      <= '0;
      discard     <= 1'b0;
      if_err_o    <= 1'b0;
      mem_err_o   <= 1'b0;
    end else begin
      if_err_o  <= 1'b0;
      mem_err_o <= 1'b0;
      if (grant_if) begin
        bus_cyc_o   <= 1'b1;
        bus_we_o    <= 1'b0;
        bus_sel_o   <= '1;
        bus_addr_o  <= if_addr_i;
        bus_wdata_o <= '0;
        tcnt        <= '0;
        streak      <= '0;
      end else if (grant_mem) begin
        bus_cyc_o   <= 1'b1;
        bus_we_o    <= mem_we_i;
        bus_sel_o   <= mem_sel_i;
        bus_addr_o  <= mem_addr_i;
        bus_wdata_o <= mem_wdata_i;
        tcnt        <= '0;
        if (!if_req_i)            streak <= '0;
        else if (streak != S_MAX) streak <= streak + 1'b1;
      end else if (state != IDLE) begin
        if (bus_ack_i) begin
          bus_cyc_o <= 1'b0;
          discard   <= 1'b0;
        end else if (timeout_hit) begin
          bus_cyc_o <= 1'b0;
          discard   <= 1'b0;
          // A flush landing on the abort edge also kills the fetch error.
          if_err_o  <= (state == IF_XFER) & ~discard & ~flush_i;
          mem_err_o <= (state == MEM_XFER);
        end else begin
          tcnt <= tcnt + 1'b1;
          if (state == IF_XFER && flush_i) discard <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios drive the two masters and a
// programmable slave; a scoreboard queue holds expected bus grants, acks and
// errors, and a negedge monitor pops and compares whenever one appears.
module tb_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int EW = 3 + AW + 1 + SW + DW;

  localparam logic [2:0] K_GRANT   = 3'd1;
  localparam logic [2:0] K_IF_ACK  = 3'd2;
  localparam logic [2:0] K_MEM_ACK = 3'd3;
  localparam logic [2:0] K_IF_ERR  = 3'd4;
  localparam logic [2:0] K_MEM_ERR = 3'd5;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          if_err;
  logic          stall_if;
  logic          mem_req;
  logic          mem_we;
  logic [SW-1:0] mem_sel;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          mem_err;
  logic          stall_mem;
  logic          bus_cyc;
  logic          bus_we;
  logic [SW-1:0] bus_sel;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;
  logic          bus_ack;
  logic [1:0]    dbg_state;

  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  int slave_delay = -1;
  int slave_cnt   = 0;
  bit late_ack    = 1'b0;

  int n_cyc, n_if_ack, n_mem_ack, n_if_err, n_mem_err;
  int first_cyc_iter, last_rise_iter, mem_ack_iter;

  bus_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16), .MEM_STREAK_MAX(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata),
    .if_ack_o(if_ack), .if_err_o(if_err), .stallreq_from_if_o(stall_if),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_sel_i(mem_sel),
    .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata),
    .mem_ack_o(mem_ack), .mem_err_o(mem_err), .stallreq_from_mem_o(stall_mem),
    .bus_cyc_o(bus_cyc), .bus_we_o(bus_we), .bus_sel_o(bus_sel),
    .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata), .bus_rdata_i(bus_rdata),
    .bus_ack_i(bus_ack), .dbg_state(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [EW-1:0] ev(input logic [2:0] k, input logic [AW-1:0] a,
                                       input logic we, input logic [SW-1:0] s,
                                       input logic [DW-1:0] d);
    return {k, a, we, s, d};
  endfunction

  task automatic chk_int(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic sb_check(input string name, input logic [EW-1:0] got);
    logic [EW-1:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL sb_%s: unexpected event %h", name, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        bad++;
        $display("FAIL sb_%s: got=%h expected=%h", name, got, e);
      end
    end
  endtask

  // Slave: acks slave_delay cycles after cyc rises (-1 never); late_ack forces one.
  initial begin
    bus_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (late_ack) begin
        bus_ack = 1'b1;
      end else if (bus_cyc && slave_delay >= 0) begin
        if (slave_cnt == slave_delay) begin
          bus_ack   = 1'b1;
          slave_cnt = 0;
        end else begin
          bus_ack   = 1'b0;
          slave_cnt = slave_cnt + 1;
        end
      end else begin
        bus_ack   = 1'b0;
        slave_cnt = 0;
      end
    end
  end

  // Monitor: every grant (cyc rising), ack and err is checked against the queue.
  initial begin
    bit prev_cyc;
    prev_cyc = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus_cyc && !prev_cyc) sb_check("grant", ev(K_GRANT, bus_addr, bus_we, bus_sel, bus_wdata));
        if (if_ack)  sb_check("if_ack",  ev(K_IF_ACK,  '0, 1'b0, '0, if_rdata));
        if (mem_ack) sb_check("mem_ack", ev(K_MEM_ACK, '0, 1'b0, '0, mem_rdata));
        if (if_err)  sb_check("if_err",  ev(K_IF_ERR,  '0, 1'b0, '0, '0));
        if (mem_err) sb_check("mem_err", ev(K_MEM_ERR, '0, 1'b0, '0, '0));
      end
      prev_cyc = bus_cyc;
    end
  end

  task automatic push_grant(input logic [AW-1:0] a, input logic we, input logic [SW-1:0] s,
                            input logic [DW-1:0] d);
    exp_q.push_back(ev(K_GRANT, a, we, s, d));
  endtask

  task automatic push_resp(input logic [2:0] k, input logic [DW-1:0] d);
    exp_q.push_back(ev(k, '0, 1'b0, '0, d));
  endtask

  // Driver: runs cycles until both masters are done, dropping each request after
  // its ack/err. hold_mem keeps MEM requesting until it completes once after IF.
  // flush_once pulses flush in the second bus cycle and redirects IF to new_addr.
  task automatic service(input bit hold_mem, input bit flush_once,
                         input logic [AW-1:0] new_addr, input int budget);
    int n;
    bit pc, di, dm, if_done, fl_now, fl_done;
    n = 0; pc = bus_cyc; if_done = 0; fl_done = 0;
    n_cyc = 0; n_if_ack = 0; n_mem_ack = 0; n_if_err = 0; n_mem_err = 0;
    first_cyc_iter = -1; last_rise_iter = -1; mem_ack_iter = -1;
    while ((if_req || mem_req) && n < budget) begin
      @(negedge clk);
      if (bus_cyc) begin
        n_cyc++;
        if (first_cyc_iter < 0) first_cyc_iter = n;
      end
      if (bus_cyc && !pc) last_rise_iter = n;
      pc = bus_cyc;
      if (if_ack) begin
        n_if_ack++;
        chk_int("stall_if_at_ack", int'(stall_if), 0);
      end
      if (mem_ack) begin
        n_mem_ack++;
        mem_ack_iter = n;
        chk_int("stall_mem_at_ack", int'(stall_mem), 0);
      end
      if (if_err)  n_if_err++;
      if (mem_err) n_mem_err++;
      di = if_ack | if_err;
      dm = mem_ack | mem_err;
      fl_now = flush_once && !fl_done && bus_cyc;
      @(posedge clk);
      #1;
      flush = fl_now;
      if (fl_now) begin
        fl_done = 1;
        if_addr = new_addr;
      end
      if (di) begin
        if_req  = 1'b0;
        if_done = 1;
      end
      if (dm && (!hold_mem || if_done)) mem_req = 1'b0;
      n++;
    end
    flush = 1'b0;
    chk_int("service_complete", int'(if_req | mem_req), 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; flush = 1'b0;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;
    bus_rdata = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_int("rst_cyc",   int'(bus_cyc), 0);
    chk_int("rst_addr",  int'(bus_addr), 0);
    chk_int("rst_we_sel", int'({bus_we, bus_sel}), 0);
    chk_int("rst_wdata", int'(bus_wdata), 0);
    chk_int("rst_resp",  int'({if_ack, mem_ack, if_err, mem_err}), 0);
    chk_int("rst_stall", int'({stall_if, stall_mem}), 0);
    chk_int("rst_state", int'(dbg_state), 0);

    // Single fetch, slave acks 2 cycles after cyc.
    slave_delay = 2;
    bus_rdata   = 32'hDEADBEEF;
    @(posedge clk); #1;
    if_addr = 32'h100; if_req = 1'b1;
    push_grant(32'h100, 1'b0, 4'hF, '0);
    push_resp(K_IF_ACK, 32'hDEADBEEF);
    @(negedge clk);
    chk_int("t1_cyc_before_edge", int'(bus_cyc), 0);
    chk_int("t1_stall_waiting", int'(stall_if), 1);
    service(1'b0, 1'b0, '0, 20);
    chk_int("t1_latency", first_cyc_iter, 0);
    chk_int("t1_cyc_cycles", n_cyc, 3);
    chk_int("t1_ack_count", n_if_ack, 1);

    // Simultaneous requests: MEM store first, IF after one idle cycle.
    slave_delay = 1;
    bus_rdata   = 32'hCAFE0001;
    @(posedge clk); #1;
    mem_we = 1'b1; mem_sel = 4'hF; mem_addr = 32'h2000; mem_wdata = 32'h12345678; mem_req = 1'b1;
    if_addr = 32'h104; if_req = 1'b1;
    push_grant(32'h2000, 1'b1, 4'hF, 32'h12345678);
    push_resp(K_MEM_ACK, 32'hCAFE0001);
    push_grant(32'h104, 1'b0, 4'hF, '0);
    push_resp(K_IF_ACK, 32'hCAFE0001);
    service(1'b0, 1'b0, '0, 30);
    chk_int("t2_idle_gap", last_rise_iter - mem_ack_iter, 2);
    chk_int("t2_acks", n_if_ack * 16 + n_mem_ack, 17);

    // Streak: MEM held with IF waiting -> 4 MEM, 1 IF, then MEM again.
    slave_delay = 0;
    bus_rdata   = 32'h55AA0003;
    @(posedge clk); #1;
    mem_we = 1'b0; mem_sel = 4'h3; mem_addr = 32'h3300; mem_wdata = '0; mem_req = 1'b1;
    if_addr = 32'h108; if_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_grant(32'h3300, 1'b0, 4'h3, '0);
      push_resp(K_MEM_ACK, 32'h55AA0003);
    end
    push_grant(32'h108, 1'b0, 4'hF, '0);
    push_resp(K_IF_ACK, 32'h55AA0003);
    push_grant(32'h3300, 1'b0, 4'h3, '0);
    push_resp(K_MEM_ACK, 32'h55AA0003);
    service(1'b1, 1'b0, '0, 60);
    chk_int("t3_mem_acks", n_mem_ack, 5);
    chk_int("t3_if_acks", n_if_ack, 1);

    // Timeout: slave never acks a load.
    slave_delay = -1;
    @(posedge clk); #1;
    mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h4000; mem_wdata = '0; mem_req = 1'b1;
    push_grant(32'h4000, 1'b0, 4'hF, '0);
    push_resp(K_MEM_ERR, '0);
    service(1'b0, 1'b0, '0, 40);
    chk_int("t4_cyc_cycles", n_cyc, 16);
    chk_int("t4_err_pulses", n_mem_err, 1);
    chk_int("t4_no_ack", n_mem_ack, 0);
    slave_delay = 1;
    bus_rdata   = 32'h0BADF00D;
    @(posedge clk); #1;
    mem_addr = 32'h4004; mem_req = 1'b1;
    push_grant(32'h4004, 1'b0, 4'hF, '0);
    push_resp(K_MEM_ACK, 32'h0BADF00D);
    service(1'b0, 1'b0, '0, 20);
    chk_int("t4_recover_ack", n_mem_ack, 1);

    // Flush during a fetch: response discarded, redirected fetch to 0x40 acks.
    slave_delay = 4;
    bus_rdata   = 32'h600D0040;
    @(posedge clk); #1;
    if_addr = 32'h80; if_req = 1'b1;
    push_grant(32'h80, 1'b0, 4'hF, '0);
    push_grant(32'h40, 1'b0, 4'hF, '0);
    push_resp(K_IF_ACK, 32'h600D0040);
    service(1'b0, 1'b1, 32'h40, 60);
    chk_int("t5_if_acks", n_if_ack, 1);
    chk_int("t5_if_errs", n_if_err, 0);

    // Reset mid MEM transfer; a late slave ack must not reach the master.
    slave_delay = -1;
    @(posedge clk); #1;
    mem_we = 1'b1; mem_sel = 4'hC; mem_addr = 32'h500; mem_wdata = 32'hA5A5A5A5; mem_req = 1'b1;
    push_grant(32'h500, 1'b1, 4'hC, 32'hA5A5A5A5);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_cyc && n < 5);
    chk_int("t6_granted", int'(bus_cyc), 1);
    @(posedge clk); #1;
    rst = 1'b1; mem_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_int("t6_cyc_after_rst", int'(bus_cyc), 0);
    chk_int("t6_state_after_rst", int'(dbg_state), 0);
    chk_int("t6_bus_after_rst", int'({bus_we, bus_sel}), 0);
    chk_int("t6_addr_after_rst", int'(bus_addr), 0);
    late_ack = 1'b1;
    @(negedge clk);
    chk_int("t6_late_ack", int'({mem_ack, if_ack}), 0);
    late_ack = 1'b0;

    // Normal fetch after the reset.
    slave_delay = 1;
    bus_rdata   = 32'h77770200;
    @(posedge clk); #1;
    if_addr = 32'h200; if_req = 1'b1;
    push_grant(32'h200, 1'b0, 4'hF, '0);
    push_resp(K_IF_ACK, 32'h77770200);
    service(1'b0, 1'b0, '0, 20);
    chk_int("t7_if_ack", n_if_ack, 1);

    repeat (3) @(negedge clk);
    chk_int("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, one-slave arbiter between the instruction-fetch port (IF) and the load/store port (MEM) of the core and the single shared system bus.
- Sequences one bus transaction at a time with a req/ack handshake.
- Enforces bounded fairness, discards fetch responses killed by a jump flush, and aborts hung transfers by timeout.
- Produces the per-master stall requests consumed by pipeline control.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 16, cycles a granted transfer may wait for bus_ack_i before abort (>=2)
- MEM_STREAK_MAX, 4, consecutive MEM grants allowed while IF waits before IF is forced

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, synchronous, active-high
- flush_i  in  1  jump flush from pipeline control; kills an in-flight fetch response
- if_req_i  in  1  fetch request, held until if_ack_o or if_err_o
- if_addr_i  in  ADDR_W  fetch address
- if_rdata_o  out  DATA_W  fetch data, valid with if_ack_o
- if_ack_o  out  1  fetch complete
- if_err_o  out  1  fetch timed out (1-cycle pulse)
- stallreq_from_if_o  out  1  if_req_i & ~if_ack_o
- mem_req_i  in  1  load/store request, held until mem_ack_o or mem_err_o
- mem_we_i  in  1  1 = store
- mem_sel_i  in  DATA_W/8  byte enables
- mem_addr_i  in  ADDR_W  data address
- mem_wdata_i  in  DATA_W  store data
- mem_rdata_o  out  DATA_W  load data, valid with mem_ack_o
- mem_ack_o  out  1  load/store complete
- mem_err_o  out  1  load/store timed out (1-cycle pulse)
- stallreq_from_mem_o  out  1  mem_req_i & ~mem_ack_o
- bus_cyc_o  out  1  transaction active (registered)
- bus_we_o  out  1  registered
- bus_sel_o  out  DATA_W/8  registered
- bus_addr_o  out  ADDR_W  registered
- bus_wdata_o  out  DATA_W  registered
- bus_rdata_i  in  DATA_W  slave read data
- bus_ack_i  in  1  slave completion, single cycle, meaningful only while bus_cyc_o=1

Behaviour:
- Reset (rst_i=1 at an edge), including mid-transfer:
  - State goes to IDLE; bus_cyc_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o go to 0.
  - Timeout counter, streak counter and discard flag clear.
  - if_err_o and mem_err_o go to 0.
  - Acks are 0 because the state is IDLE.
- States:
  - IDLE: no transaction in progress.
  - IF_XFER, MEM_XFER: a granted transfer is on the bus.
- IDLE arbitration, evaluated each cycle on registered state:
  - Only one request: grant it.
  - Both requests: grant MEM unless streak == MEM_STREAK_MAX, then grant IF.
  - On grant, the next edge latches the master's address, we, sel and wdata onto bus_* and sets bus_cyc_o=1.
  - IF grants drive we=0 and sel all-ones.
  - Latency: request sampled at edge t, bus_cyc_o high after edge t+1.
- Streak counter:
  - +1 (saturating at MEM_STREAK_MAX) on a MEM grant while if_req_i=1.
  - Cleared on any IF grant, and on a MEM grant while if_req_i=0.
- XFER completion:
  - Master ack = bus_ack_i & (state matches) & ~discard, combinational.
  - rdata_o = bus_rdata_i passes through.
  - Ack edge: state returns to IDLE and bus_cyc_o drops.
  - No back-to-back grant on the ack edge: minimum one IDLE cycle between transactions.
- Timeout counter:
  - Clears on grant; increments each XFER cycle without ack.
  - When it reaches TIMEOUT_CYCLES-1 with no ack, the next edge aborts: IDLE, bus_cyc_o=0, owner err_o=1 for exactly one cycle, no ack.
  - If ack and timeout coincide in the same cycle, ack wins.
- Flush:
  - flush_i=1 in IF_XFER sets discard. The bus transfer still completes (or times out), but if_ack_o and if_err_o are suppressed.
  - discard clears on return to IDLE.
  - flush_i in IDLE or MEM_XFER has no effect.
- Master requests dropped mid-XFER do not cancel the bus transfer.
- The stall outputs are combinational and never asserted during reset, because req is gated by the master's own reset.
- mem_rdata_o and if_rdata_o are don't-care when the corresponding ack is 0.

Test Plan:
- Reset, then if_req_i=1, addr 0x100, slave ack 2 cycles after bus_cyc_o -> bus_cyc_o high after 1 edge, bus_addr_o=0x100, bus_we_o=0, if_ack_o for 1 cycle with rdata 0xDEADBEEF, stallreq_from_if_o low the same cycle.
- if_req_i and mem_req_i both raised in the same cycle, store to 0x2000 with sel=0xF -> MEM granted first with bus_we_o=1 and wdata correct; IF granted after one IDLE cycle.
- mem_req_i held continuously with if_req_i=1 -> exactly 4 MEM grants, then 1 IF grant, then MEM resumes with streak reset.
- Slave never acks a MEM load -> bus_cyc_o drops after 16 cycles; mem_err_o pulses 1 cycle; mem_ack_o never asserts; next request is served normally.
- flush_i pulsed during IF_XFER, ack 3 cycles later -> bus transfer completes; if_ack_o stays 0; a following fetch to 0x40 acks normally.
- rst_i asserted mid MEM_XFER -> next edge bus_cyc_o=0, state IDLE; a late bus_ack_i produces no mem_ack_o.
